// File: rtl/fft_input_loader.sv
// Stream-to-memory loader for the 32-point FFT: stores one frame, pulses start_fft, waits for fft_done.
// Define FFT_LOADER_BITREV_EN to write samples at bit-reversed addresses; natural order otherwise.
module fft_input_loader #(
  parameter int N_POINTS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              start_fft,
  input  logic              fft_done,
  output logic              busy,
  output logic              frame_err,
  output logic [15:0]       frame_cnt
);

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_nxt;
  logic              busy_nxt;
  logic [15:0]       cnt_nxt;
  logic              err_nxt;
  logic              accept;
  logic              at_last;

  function automatic logic [ADDR_W-1:0] map_addr(
    input logic [ADDR_W-1:0] i
  );
    logic [ADDR_W-1:0] r;
    r = '0;
`ifdef FFT_LOADER_BITREV_EN
    for (int b = 0; b < ADDR_W; b++) begin
      r[b] = i[ADDR_W-1-b];
    end
`else
    r = i;
`endif
    return r;
  endfunction

  // Ready is forced low while reset is asserted, not only by state.
  assign s_ready = rst_n && (state == LOAD);
  assign accept  = s_valid && s_ready;
  assign at_last = (idx == LAST_IDX);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    busy_nxt  = busy;
    cnt_nxt   = frame_cnt;
    err_nxt   = 1'b0;
    unique case (state)
      LOAD: begin
        if (accept) begin
          busy_nxt = 1'b1;
          if (at_last) begin
            idx_nxt   = '0;
            state_nxt = START;
            err_nxt   = !s_last;
          end else if (s_last) begin
            // Early s_last truncates the frame; restart at index 0.
            idx_nxt = '0;
            err_nxt = 1'b1;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      START: begin
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (fft_done) begin
          cnt_nxt   = frame_cnt + 16'd1;
          idx_nxt   = '0;
          busy_nxt  = 1'b0;
          state_nxt = LOAD;
        end
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      idx       <= '0;
      busy      <= 1'b0;
      frame_cnt <= '0;
      frame_err <= 1'b0;
      start_fft <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      busy      <= busy_nxt;
      frame_cnt <= cnt_nxt;
      frame_err <= err_nxt;
      start_fft <= (state == START);
      mem_we    <= accept;
      if (accept) begin
        mem_addr <= map_addr(idx);
        mem_din  <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader: frames, gaps, s_last errors, resets.
// Expected addresses follow FFT_LOADER_BITREV_EN when defined.
module tb_fft_input_loader;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic [63:0] s_data;
  logic        s_last;
  logic        s_ready;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [63:0] mem_din;
  logic        start_fft;
  logic        fft_done;
  logic        busy;
  logic        frame_err;
  logic [15:0] frame_cnt;

  fft_input_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .start_fft (start_fft),
    .fft_done  (fft_done),
    .busy      (busy),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_tot;
  int cyc;
  int wr_cnt;
  int st_cnt;
  int err_cnt;
  int acc_cyc;
  int st_cyc;
  logic [4:0]  last_addr;
  logic [63:0] last_din;
  logic [63:0] mem_img [32];

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [4:0] f_addr(input int i);
    logic [4:0] v;
    v = 5'(i);
`ifdef FFT_LOADER_BITREV_EN
    return {v[0], v[1], v[2], v[3], v[4]};
`else
    return v;
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (s_valid && s_ready) acc_cyc = cyc;
    if (mem_we) begin
      wr_cnt++;
      mem_img[mem_addr] = mem_din;
      last_addr = mem_addr;
      last_din  = mem_din;
    end
    if (start_fft) begin
      st_cnt++;
      st_cyc = cyc;
    end
    if (frame_err) err_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    @(posedge clk);
    #1;
    wr_cnt  = 0;
    st_cnt  = 0;
    err_cnt = 0;
    for (int i = 0; i < 32; i++) mem_img[i] = '1;
  endtask

  task automatic send_beat(
    input logic [63:0] d,
    input logic        last,
    input bit          gaps
  );
    int n;
    if (gaps) begin
      for (int g = 0; g < 3 && $urandom_range(1, 0) == 1; g++) begin
        s_valid = 1'b0;
        tick(1);
      end
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    while (!s_ready && n < 200) begin
      tick(1);
      n++;
    end
    if (n >= 200) check("ready_timeout", {63'd0, s_ready}, 64'd1);
    tick(1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
  endtask

  task automatic send_range(
    input logic [31:0] tag,
    input int          lo,
    input int          hi,
    input int          last_at,
    input bit          gaps
  );
    for (int i = lo; i <= hi; i++) begin
      send_beat({tag, 32'(i)}, i == last_at, gaps);
    end
  endtask

  task automatic check_img(input string tag, input logic [31:0] rtag);
    int bad;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (mem_img[f_addr(i)] !== {rtag, 32'(i)}) bad++;
    end
    check(tag, 64'(bad), 64'd0);
  endtask

  task automatic pulse_done(input int len);
    fft_done = 1'b1;
    tick(len);
    fft_done = 1'b0;
  endtask

  initial begin
    n_pass   = 0;
    n_tot    = 0;
    cyc      = 0;
    wr_cnt   = 0;
    st_cnt   = 0;
    err_cnt  = 0;
    acc_cyc  = 0;
    st_cyc   = 0;
    rst_n    = 1'b0;
    s_valid  = 1'b1;
    s_data   = 64'hDEAD_BEEF_0BAD_F00D;
    s_last   = 1'b1;
    fft_done = 1'b0;
    for (int i = 0; i < 32; i++) mem_img[i] = '1;

    // Reset held with valid input present.
    tick(4);
    check("rst_ready", {63'd0, s_ready}, 64'd0);
    check("rst_we_cnt", 64'(wr_cnt), 64'd0);
    check("rst_addr", {59'd0, mem_addr}, 64'd0);
    check("rst_din", mem_din, 64'd0);
    check("rst_start", {63'd0, start_fft}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_err", {63'd0, frame_err}, 64'd0);
    check("rst_cnt", {48'd0, frame_cnt}, 64'd0);
    s_valid = 1'b0;
    s_last  = 1'b0;
    rst_n   = 1'b1;
    tick(1);
    check("rel_ready", {63'd0, s_ready}, 64'd1);

    // Full frame, continuous valid.
    clear_mon();
    send_range(32'h1000_0000, 0, 31, 31, 1'b0);
    tick(3);
    check("f1_writes", 64'(wr_cnt), 64'd32);
    check_img("f1_img", 32'h1000_0000);
    check("f1_idx1", mem_img[f_addr(1)], {32'h1000_0000, 32'd1});
    check("f1_idx31", mem_img[31], {32'h1000_0000, 32'd31});
`ifdef FFT_LOADER_BITREV_EN
    check("f1_addr16", mem_img[16], {32'h1000_0000, 32'd1});
    check("f1_addr24", mem_img[24], {32'h1000_0000, 32'd3});
`endif
    check("f1_starts", 64'(st_cnt), 64'd1);
    check("f1_latency", 64'(st_cyc - acc_cyc), 64'd2);
    check("f1_ready", {63'd0, s_ready}, 64'd0);
    check("f1_busy", {63'd0, busy}, 64'd1);
    check("f1_err", 64'(err_cnt), 64'd0);

    // fft_done after 40 cycles, held high for 3.
    tick(37);
    check("f1_wait_cnt", {48'd0, frame_cnt}, 64'd0);
    fft_done = 1'b1;
    tick(1);
    check("done_cnt", {48'd0, frame_cnt}, 64'd1);
    check("done_ready", {63'd0, s_ready}, 64'd1);
    check("done_busy", {63'd0, busy}, 64'd0);
    tick(2);
    fft_done = 1'b0;
    tick(1);
    check("done_held", {48'd0, frame_cnt}, 64'd1);

    // Second frame with random valid gaps.
    clear_mon();
    send_range(32'h2000_0000, 0, 31, 31, 1'b1);
    tick(3);
    check("f2_writes", 64'(wr_cnt), 64'd32);
    check_img("f2_img", 32'h2000_0000);
    check("f2_starts", 64'(st_cnt), 64'd1);
    check("f2_latency", 64'(st_cyc - acc_cyc), 64'd2);
    // Valid while not ready must be ignored.
    s_valid = 1'b1;
    s_data  = 64'hBAD0_BAD0_BAD0_BAD0;
    tick(5);
    s_valid = 1'b0;
    check("f2_stall_wr", 64'(wr_cnt), 64'd32);
    pulse_done(1);
    check("f2_cnt", {48'd0, frame_cnt}, 64'd2);

    // Early s_last at idx 10 truncates.
    clear_mon();
    send_range(32'h3000_0000, 0, 10, 10, 1'b0);
    tick(3);
    check("tr_err", 64'(err_cnt), 64'd1);
    check("tr_starts", 64'(st_cnt), 64'd0);
    check("tr_ready", {63'd0, s_ready}, 64'd1);
    send_beat(64'h4000_0000_0000_0000, 1'b0, 1'b0);
    tick(1);
    check("tr_restart_addr", {59'd0, last_addr}, {59'd0, f_addr(0)});
    check("tr_restart_din", last_din, 64'h4000_0000_0000_0000);
    // Remaining beats with s_last missing on idx 31.
    send_range(32'h4000_0000, 1, 31, -1, 1'b0);
    tick(3);
    check("ml_err", 64'(err_cnt), 64'd2);
    check("ml_starts", 64'(st_cnt), 64'd1);
    check("ml_writes", 64'(wr_cnt), 64'd43);
    check_img("ml_img", 32'h4000_0000);
    pulse_done(1);
    check("ml_cnt", {48'd0, frame_cnt}, 64'd3);

    // Reset while waiting for fft_done.
    send_range(32'h5000_0000, 0, 31, 31, 1'b0);
    tick(4);
    rst_n = 1'b0;
    #1;
    check("rw_cnt", {48'd0, frame_cnt}, 64'd0);
    check("rw_busy", {63'd0, busy}, 64'd0);
    check("rw_ready", {63'd0, s_ready}, 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("rw_ready_rel", {63'd0, s_ready}, 64'd1);

    // Reset mid-frame at idx 20.
    clear_mon();
    send_range(32'h6000_0000, 0, 19, -1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rm_busy", {63'd0, busy}, 64'd0);
    check("rm_we", {63'd0, mem_we}, 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("rm_starts", 64'(st_cnt), 64'd0);
    clear_mon();
    send_range(32'h7000_0000, 0, 31, 31, 1'b0);
    tick(3);
    check_img("rm_img", 32'h7000_0000);
    check("rm_starts2", 64'(st_cnt), 64'd1);
    pulse_done(1);
    check("rm_cnt", {48'd0, frame_cnt}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
